// File: rtl/fetch_cycle.sv
// IF stage with IF/ID pipeline register: owns PCF, fetches over a req/gnt/rvalid
// instruction-memory handshake (one request in flight), and feeds D with bubbles when idle.
module fetch_cycle #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD
);

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_HOLD, S_DROP} state_t;

  state_t      state, state_n;
  logic [31:0] pcf, pcf_n;
  logic [31:0] ipc, ipc_n;
  logic [31:0] hold_instr, hold_instr_n;
  logic [31:0] ipc_plus4;
  logic        deliver;
  logic [31:0] deliver_instr;

  assign ipc_plus4 = ipc + 32'd4;
  assign imem_addr = pcf;

  always_comb begin
    state_n       = state;
    pcf_n         = pcf;
    ipc_n         = ipc;
    hold_instr_n  = hold_instr;
    deliver       = 1'b0;
    deliver_instr = imem_rdata;
    imem_req      = 1'b0;

    case (state)
      S_REQ: begin
        imem_req = 1'b1;
        if (imem_gnt) begin
          ipc_n   = pcf;
          state_n = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          if (StallD) begin
            hold_instr_n = imem_rdata;
            state_n      = S_HOLD;
          end else begin
            deliver = 1'b1;
            pcf_n   = ipc_plus4;
            state_n = S_REQ;
          end
        end
      end
      S_HOLD: begin
        if (!StallD) begin
          deliver       = 1'b1;
          deliver_instr = hold_instr;
          pcf_n         = ipc_plus4;
          state_n       = S_REQ;
        end
      end
      S_DROP: begin
        if (imem_rvalid) state_n = S_REQ;
      end
      default: state_n = S_REQ;
    endcase

    // A redirect overrides stall and any pending delivery; an un-returned request becomes stale.
    if (PCSrcE) begin
      deliver      = 1'b0;
      pcf_n        = PCTargetE;
      hold_instr_n = hold_instr;
      case (state)
        S_REQ:          state_n = imem_gnt ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_n = imem_rvalid ? S_REQ : S_DROP;
        default:        state_n = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_REQ;
      pcf        <= RESET_PC;
      ipc        <= '0;
      hold_instr <= '0;
    end else begin
      state      <= state_n;
      pcf        <= pcf_n;
      ipc        <= ipc_n;
      hold_instr <= hold_instr_n;
    end
  end

  // Flush beats stall; stall holds D; otherwise D takes the delivery or a bubble.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (FlushD || (!StallD && !deliver)) begin
      InstrD   <= NOP_INSTR;
      PCD      <= '0;
      PCPlus4D <= '0;
      ValidD   <= 1'b0;
    end else if (!StallD) begin
      InstrD   <= deliver_instr;
      PCD      <= ipc;
      PCPlus4D <= ipc_plus4;
      ValidD   <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_cycle.sv
// Scoreboard bench for fetch_cycle: randomized memory/hazard stimulus, transaction-level
// reference model predicting fetch addresses and every D-stage value.
`timescale 1ns/1ps
module tb_fetch_cycle;
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic        valid;
  } d_t;
  localparam d_t BUBBLE = '{instr: NOP, pc: 32'h0, pc4: 32'h0, valid: 1'b0};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD;

  always #5 clk = ~clk;

  fetch_cycle #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .StallD(StallD), .FlushD(FlushD), .PCSrcE(PCSrcE),
    .PCTargetE(PCTargetE), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D), .ValidD(ValidD)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return 32'hAAAA_0000 + a;
  endfunction

  // Scoreboard: expected D contents are queued when the model sees a delivery.
  d_t          exp_q[$];
  d_t          last_d = BUBBLE;
  bit          hold_d = 1'b0;
  logic [31:0] exp_pc = '0;
  logic [31:0] txn_pc = '0;
  bit          txn_live = 1'b0, txn_resp = 1'b0, txn_dead = 1'b0;

  always @(negedge clk) begin
    d_t e;
    if (!rst) begin
      exp_q.delete();
      last_d   = BUBBLE;
      hold_d   = 1'b0;
      exp_pc   = 32'h0;
      txn_live = 1'b0;
      txn_resp = 1'b0;
      txn_dead = 1'b0;
    end else begin
      if (hold_d) begin
        e = last_d;
      end else if (ValidD) begin
        chk("sb_available", 32'(exp_q.size() > 0), 32'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : BUBBLE;
      end else begin
        chk("sb_missed_delivery", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        e = BUBBLE;
      end
      chk("d_instr", InstrD, e.instr);
      chk("d_pc", PCD, e.pc);
      chk("d_pc4", PCPlus4D, e.pc4);
      chk("d_valid", 32'(ValidD), 32'(e.valid));
      last_d = e;
      hold_d = StallD && !FlushD;

      if (imem_req) chk("fetch_addr", imem_addr, exp_pc);
      if (txn_live && !txn_resp && imem_rvalid) txn_resp = 1'b1;
      if (txn_live && txn_resp && !txn_dead && !PCSrcE && !StallD) begin
        txn_live = 1'b0;
        exp_pc   = txn_pc + 32'd4;
        if (!FlushD) exp_q.push_back('{instr: memf(txn_pc), pc: txn_pc, pc4: txn_pc + 32'd4, valid: 1'b1});
      end
      if (txn_live && txn_resp && txn_dead) txn_live = 1'b0;
      if (PCSrcE) begin
        exp_pc = PCTargetE;
        if (txn_live) begin
          if (txn_resp) txn_live = 1'b0;
          else          txn_dead = 1'b1;
        end
      end
      if (imem_req && imem_gnt) begin
        txn_live = 1'b1;
        txn_pc   = imem_addr;
        txn_resp = 1'b0;
        txn_dead = PCSrcE;
      end
    end
  end

  // Memory responder state, owned by the stimulus process.
  bit          outstanding = 1'b0;
  logic [31:0] out_addr = '0;
  int unsigned lat = 0;

  task automatic step(input bit st, input bit fl, input bit ps, input logic [31:0] tg,
                      input bit gnt_en, input int unsigned lmin, input int unsigned lmax);
    bit          granted;
    logic [31:0] gaddr;
    granted = imem_req && imem_gnt;
    gaddr   = imem_addr;
    @(posedge clk);
    #1;
    imem_rvalid = 1'b0;
    imem_rdata  = $urandom;
    if (!rst) begin
      outstanding = 1'b0;
      granted     = 1'b0;
    end
    if (granted) begin
      outstanding = 1'b1;
      out_addr    = gaddr;
      lat         = $urandom_range(lmax, lmin);
    end
    if (outstanding) begin
      if (lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = memf(out_addr);
        outstanding = 1'b0;
      end else begin
        lat--;
      end
    end
    StallD    = st;
    FlushD    = fl;
    PCSrcE    = ps;
    PCTargetE = tg;
    imem_gnt  = gnt_en && imem_req;
  endtask

  initial begin
    int  nval;
    bit  found;
    logic [31:0] tg;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr", InstrD, NOP);
    chk("rst_pcd", PCD, 32'h0);
    chk("rst_pc4", PCPlus4D, 32'h0);
    chk("rst_valid", 32'(ValidD), 32'd0);
    chk("rst_req", 32'(imem_req), 32'd1);
    chk("rst_addr", imem_addr, 32'h0);
    rst = 1'b1;

    for (int i = 0; i < 3; i++) begin
      chk("nognt_req", 32'(imem_req), 32'd1);
      chk("nognt_addr", imem_addr, 32'h0);
      chk("nognt_valid", 32'(ValidD), 32'd0);
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0);
    end

    nval = 0;
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
      if (ValidD) nval++;
    end
    chk("seq_deliveries", 32'(nval >= 5), 32'd1);

    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (!found) begin
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0, 1);
        if (ValidD && PCD == 32'hFFFF_FFFC) begin
          found = 1'b1;
          chk("wrap_pc4", PCPlus4D, 32'h0);
        end
      end
    end
    chk("wrap_seen", 32'(found), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      tg = {$urandom_range(0, 3) == 0 ? 16'hFFFF : 16'h0000, 16'($urandom)} & 32'hFFFF_FFFC;
      step($urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 9) == 0, tg,
           $urandom_range(0, 3) != 0, 0, 3);
    end

    // Reset mid-WAIT must return PCF and the FSM to their reset values at once.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0);
    step(1'b0, 1'b0, 1'b1, 32'h0000_0200, 1'b0, 0, 0);
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (!found) begin
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 6, 6);
        found = outstanding;
      end
    end
    chk("wait_reached", 32'(found), 32'd1);
    chk("wait_no_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd1);
    chk("midrst_addr", imem_addr, 32'h0);
    chk("midrst_valid", 32'(ValidD), 32'd0);
    step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 0, 0);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 0, 0);
    @(negedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
